// File: rtl/systolic_result_drain.sv
// Captures a completed systolic-array result on the rising edge of done_matrix_mult
// and streams it out one element per beat over valid/ready with row/col/last tags.
module systolic_result_drain #(
  parameter int N         = 4,
  parameter int DATA_W    = 32,
  parameter int COL_MAJOR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done_matrix_mult,
  input  logic [N*N*DATA_W-1:0]     y,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [$clog2(N)-1:0]      m_row,
  output logic [$clog2(N)-1:0]      m_col,
  output logic                      m_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int NE    = N * N;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;
  localparam int RC_W  = $clog2(N);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NE*DATA_W-1:0]    buf_q, buf_d;
  logic                    done_q, done_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_W-1:0]       m_data_q, m_data_d;
  logic [RC_W-1:0]         m_row_q, m_row_d;
  logic [RC_W-1:0]         m_col_q, m_col_d;
  logic                    m_last_q, m_last_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic                    rise;
  logic                    accept;
  logic                    capture;
  logic [IDX_W-1:0]        idx_inc;

  logic [DATA_W-1:0]       y_elem   [NE];
  logic [DATA_W-1:0]       buf_elem [NE];

  // Element (r,c) lives at slot r*N+c counted from the MSB end of the bus.
  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
      assign y_elem[gi]   = y[DATA_W*(NE-1-gi) +: DATA_W];
      assign buf_elem[gi] = buf_q[DATA_W*(NE-1-gi) +: DATA_W];
    end
  endgenerate

  function automatic logic [RC_W-1:0] row_of(input logic [IDX_W-1:0] idx);
    int i;
    i = int'(idx);
    return (COL_MAJOR != 0) ? RC_W'(i % N) : RC_W'(i / N);
  endfunction

  function automatic logic [RC_W-1:0] col_of(input logic [IDX_W-1:0] idx);
    int i;
    i = int'(idx);
    return (COL_MAJOR != 0) ? RC_W'(i / N) : RC_W'(i % N);
  endfunction

  // Maps a beat index to its slot in the row-major snapshot.
  function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] idx);
    return IDX_W'(int'(row_of(idx)) * N + int'(col_of(idx)));
  endfunction

  always_comb begin
    rise    = done_matrix_mult & ~done_q;
    accept  = m_valid_q & m_ready;
    idx_inc = idx_q + IDX_W'(1);
    // A completion is only taken when idle or exactly as the final beat leaves.
    capture = rise && ((state_q == IDLE) || (accept && m_last_q));

    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    done_d    = done_matrix_mult;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_row_d   = m_row_q;
    m_col_d   = m_col_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    overrun_d = 1'b0;

    if (capture) begin
      state_d   = STREAM;
      buf_d     = y;
      idx_d     = '0;
      m_valid_d = 1'b1;
      busy_d    = 1'b1;
      m_data_d  = y_elem[0];
      m_row_d   = '0;
      m_col_d   = '0;
      m_last_d  = (NE == 1);
    end else if (state_q == STREAM) begin
      overrun_d = rise;
      if (accept) begin
        if (m_last_q) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          busy_d    = 1'b0;
          m_last_d  = 1'b0;
        end else begin
          idx_d    = idx_inc;
          m_data_d = buf_elem[slot_of(idx_inc)];
          m_row_d  = row_of(idx_inc);
          m_col_d  = col_of(idx_inc);
          m_last_d = (idx_inc == IDX_W'(NE - 1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_row_q   <= '0;
      m_col_q   <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_row_q   <= m_row_d;
      m_col_q   <= m_col_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_row   = m_row_q;
  assign m_col   = m_col_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: row-major and column-major instances share stimulus and
// are compared every cycle against a queue-based model, plus a constant vector table.
module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NE = N * N;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              done = 1'b0;
  logic [NE*DW-1:0]  y = '0;
  logic              m_ready = 1'b0;

  logic              rm_valid, rm_last, rm_busy, rm_ov;
  logic [DW-1:0]     rm_data;
  logic [1:0]        rm_row, rm_col;
  logic              cm_valid, cm_last, cm_busy, cm_ov;
  logic [DW-1:0]     cm_data;
  logic [1:0]        cm_row, cm_col;

  always #5 clk = ~clk;

  systolic_result_drain #(.N(N), .DATA_W(DW), .COL_MAJOR(0)) u_rm (
    .clk(clk), .reset(reset), .done_matrix_mult(done), .y(y),
    .m_valid(rm_valid), .m_ready(m_ready), .m_data(rm_data),
    .m_row(rm_row), .m_col(rm_col), .m_last(rm_last),
    .busy(rm_busy), .overrun(rm_ov)
  );

  systolic_result_drain #(.N(N), .DATA_W(DW), .COL_MAJOR(1)) u_cm (
    .clk(clk), .reset(reset), .done_matrix_mult(done), .y(y),
    .m_valid(cm_valid), .m_ready(m_ready), .m_data(cm_data),
    .m_row(cm_row), .m_col(cm_col), .m_last(cm_last),
    .busy(cm_busy), .overrun(cm_ov)
  );

  int checks = 0;
  int failures = 0;
  int beats = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: each captured result becomes a queue of expected beats.
  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [1:0]    c;
  } elt_t;

  elt_t          qr[$];
  elt_t          qc[$];
  logic          mdl_prev = 1'b0;
  logic          mdl_ov = 1'b0;
  logic          mdl_zero = 1'b1;
  logic [DW-1:0] elem [NE];

  function automatic logic [DW-1:0] y_at(input int r, input int c);
    return y[DW*(NE-1-(r*N+c)) +: DW];
  endfunction

  task automatic model_step();
    logic rise, had, fin;
    elt_t e;
    if (!reset) begin
      qr.delete();
      qc.delete();
      mdl_prev = 1'b0;
      mdl_ov   = 1'b0;
      mdl_zero = 1'b1;
      return;
    end
    rise     = done && !mdl_prev;
    mdl_prev = done;
    had      = (qr.size() > 0);
    fin      = 1'b0;
    if (had && m_ready) begin
      void'(qr.pop_front());
      void'(qc.pop_front());
      fin = (qr.size() == 0);
    end
    mdl_ov = rise && had && !fin;
    if (rise && (!had || fin)) begin
      mdl_zero = 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          e.d = y_at(r, c); e.r = 2'(r); e.c = 2'(c);
          qr.push_back(e);
        end
      for (int c = 0; c < N; c++)
        for (int r = 0; r < N; r++) begin
          e.d = y_at(r, c); e.r = 2'(r); e.c = 2'(c);
          qc.push_back(e);
        end
    end
  endtask

  task automatic model_check();
    logic ev;
    ev = (qr.size() > 0);
    chk("valid_rm", rm_valid, ev);
    chk("valid_cm", cm_valid, ev);
    chk("busy_rm", rm_busy, ev);
    chk("busy_cm", cm_busy, ev);
    chk("last_rm", rm_last, qr.size() == 1);
    chk("last_cm", cm_last, qc.size() == 1);
    chk("overrun_rm", rm_ov, mdl_ov);
    chk("overrun_cm", cm_ov, mdl_ov);
    if (ev) begin
      chk("data_rm", rm_data, qr[0].d);
      chk("row_rm", rm_row, qr[0].r);
      chk("col_rm", rm_col, qr[0].c);
      chk("data_cm", cm_data, qc[0].d);
      chk("row_cm", cm_row, qc[0].r);
      chk("col_cm", cm_col, qc[0].c);
    end else if (mdl_zero) begin
      chk("zero_data_rm", rm_data, 0);
      chk("zero_rowcol_rm", {rm_row, rm_col}, 0);
      chk("zero_data_cm", cm_data, 0);
      chk("zero_rowcol_cm", {cm_row, cm_col}, 0);
    end
  endtask

  task automatic cycle();
    model_step();
    if (reset && rm_valid && m_ready) begin
      beats++;
      $display("beat %0d: rm data=%0d (%0d,%0d) last=%0b | cm data=%0d (%0d,%0d) last=%0b",
               beats, $signed(rm_data), rm_row, rm_col, rm_last,
               $signed(cm_data), cm_row, cm_col, cm_last);
    end
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set_y_base(input int base);
    for (int k = 0; k < NE; k++) elem[k] = DW'(base + k);
    for (int k = 0; k < NE; k++) y[DW*(NE-1-k) +: DW] = elem[k];
  endtask

  typedef struct {
    logic          done;
    logic          rdy;
    int            base;
    logic          ev;
    logic [DW-1:0] rd;
    int            rr;
    int            rc;
    logic [DW-1:0] cd;
    int            cr;
    int            cc;
    logic          el;
    logic          eov;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cnt, ovc;
    logic found;

    vecs[0]  = '{1'b1, 1'b0,   1, 1'b1, 32'd1, 0, 0, 32'd1,  0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0,   1, 1'b1, 32'd1, 0, 0, 32'd1,  0, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1,   1, 1'b1, 32'd2, 0, 1, 32'd5,  1, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0,   1, 1'b1, 32'd2, 0, 1, 32'd5,  1, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0,   1, 1'b1, 32'd2, 0, 1, 32'd5,  1, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1,   1, 1'b1, 32'd3, 0, 2, 32'd9,  2, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1,   1, 1'b1, 32'd4, 0, 3, 32'd13, 3, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1,   1, 1'b1, 32'd5, 1, 0, 32'd2,  0, 1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0,   1, 1'b1, 32'd5, 1, 0, 32'd2,  0, 1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 100, 1'b1, 32'd6, 1, 1, 32'd6,  1, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 100, 1'b1, 32'd7, 1, 2, 32'd10, 2, 1, 1'b0, 1'b0};

    // Reset state
    reset = 1'b0; done = 1'b0; m_ready = 1'b0; set_y_base(1);
    cycle(); cycle();
    chk("reset_valid", rm_valid, 0);
    chk("reset_busy", rm_busy, 0);
    reset = 1'b1;
    cycle(); cycle();

    // Constant table: capture latency, backpressure hold, overrun with buffer isolation
    for (int i = 0; i < 11; i++) begin
      done = vecs[i].done; m_ready = vecs[i].rdy; set_y_base(vecs[i].base);
      cycle();
      chk($sformatf("vec%0d_valid", i), rm_valid, vecs[i].ev);
      chk($sformatf("vec%0d_rm", i), {rm_data, 2'(vecs[i].rr), 2'(vecs[i].rc)},
          {vecs[i].rd, rm_row, rm_col});
      chk($sformatf("vec%0d_rm_rc", i), {rm_row, rm_col}, {2'(vecs[i].rr), 2'(vecs[i].rc)});
      chk($sformatf("vec%0d_cm", i), cm_data, vecs[i].cd);
      chk($sformatf("vec%0d_cm_rc", i), {cm_row, cm_col}, {2'(vecs[i].cr), 2'(vecs[i].cc)});
      chk($sformatf("vec%0d_last", i), rm_last, vecs[i].el);
      chk($sformatf("vec%0d_ov", i), rm_ov, vecs[i].eov);
    end
    done = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    chk("drain1_busy_end", rm_busy, 0);

    // Level held for 40 cycles: one drain, no overrun
    set_y_base(1); done = 1'b1; cnt = 0; ovc = 0;
    for (int i = 0; i < 40; i++) begin
      if (rm_valid && m_ready) cnt++;
      cycle();
      if (rm_ov) ovc++;
    end
    chk("hold_beats", cnt, 16);
    chk("hold_overruns", ovc, 0);
    done = 1'b0; cycle(); cycle();

    // Back-to-back: new rise exactly as the last beat is accepted
    set_y_base(1); done = 1'b1; cycle(); done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (rm_valid && rm_last) begin
        found = 1'b1;
        done = 1'b1; set_y_base(100);
        cycle();
        chk("b2b_valid", rm_valid, 1);
        chk("b2b_data", rm_data, 100);
        chk("b2b_rowcol", {rm_row, rm_col}, 0);
        done = 1'b0;
      end else begin
        cycle();
      end
    end
    chk("b2b_last_seen", found, 1);
    for (int i = 0; i < 18; i++) cycle();

    // Reset after 7 accepted beats, then done already high when reset releases
    set_y_base(1); done = 1'b1; cycle(); done = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("pre_reset_data", rm_data, 8);
    reset = 1'b0; done = 1'b1;
    cycle();
    chk("mid_reset_valid", rm_valid, 0);
    chk("mid_reset_busy", rm_busy, 0);
    chk("mid_reset_rowcol", {rm_row, rm_col}, 0);
    reset = 1'b1;
    cycle();
    chk("post_reset_valid", rm_valid, 1);
    chk("post_reset_data", rm_data, 1);
    chk("post_reset_rowcol", {rm_row, rm_col}, 0);
    done = 1'b0;
    for (int i = 0; i < 18; i++) cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) done = ~done;
      m_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < NE; k++) y[DW*(NE-1-k) +: DW] = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumer side of the systolic array's result interface.
- Detects completion of a matrix multiply on `done_matrix_mult` and snapshots the packed `N*N` result bus `y`.
- Streams the result out one element per beat on a valid/ready interface, tagged with row/column indices and a last flag.
- Sits between the systolic array top and the downstream writeback or host path, freeing the array to start the next multiply while results drain.

Parameters:
- N, 4: matrix dimension; `N*N` elements per result.
- DATA_W, 32: width of one result element (signed partial sum).
- COL_MAJOR, 0: output order. 0 = row-major (0,0),(0,1)…; 1 = column-major (0,0),(1,0)….

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- done_matrix_mult  in  1  completion level from the systolic array; may stay high for many cycles.
- y  in  N*N*DATA_W  packed result. Element (r,c) sits at bits [DATA_W*(N*N-1-(r*N+c)) +: DATA_W], so (0,0) occupies the MSBs.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts the element when m_valid && m_ready.
- m_data  out  DATA_W  current element.
- m_row  out  $clog2(N)  row index of m_data.
- m_col  out  $clog2(N)  column index of m_data.
- m_last  out  1  high on the final (N*N-th) beat of a result.
- busy  out  1  high while a captured result is not fully drained.
- overrun  out  1  one-cycle pulse when a completion is dropped.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; m_valid, m_last, busy, overrun = 0; m_data, m_row, m_col = 0.
  - Beat index = 0; snapshot buffer = 0; done_d = 0.
- Edge detect:
  - done_d <= done_matrix_mult each cycle.
  - rise = done_matrix_mult & ~done_d. Only rise triggers capture; a held-high level never re-triggers.
  - done_matrix_mult already high on the first cycle after reset counts as a rise.
- FSM has 2 states: IDLE and STREAM.
- IDLE:
  - On rise: buffer <= y, index <= 0, state -> STREAM.
  - m_valid first goes high the cycle after the rise (capture latency 1).
  - Without rise: remain in IDLE, m_valid=0.
- STREAM:
  - m_valid=1 and busy=1.
  - m_data, m_row, m_col reflect the current index, registered from the buffer. They change only on an accepted beat.
  - m_valid && !m_ready: all outputs hold stable; m_valid is never dropped before acceptance.
  - Accept (m_valid && m_ready): index++. Next element is issued the following cycle, giving full throughput of 1 beat/cycle with m_ready held high.
  - Index → (row,col): COL_MAJOR=0: row=idx/N, col=idx%N. COL_MAJOR=1: col=idx/N, row=idx%N.
  - m_last=1 exactly when idx==N*N-1.
  - Accept with m_last:
    - Without a simultaneous rise: state -> IDLE, m_valid=0 next cycle.
    - With a simultaneous rise: capture the new y, index <= 0, stay in STREAM. Element 0 of the new result appears next cycle (no bubble).
  - Rise in STREAM other than the final-accept cycle: new result dropped, buffer unchanged, overrun=1 for exactly one cycle, drain continues.
- Buffer is written only on capture; changes to y after capture do not affect the stream.
- No arithmetic on data: elements pass through bit-exact, sign preserved.
- Reset mid-stream: abort immediately to the reset values above; the partial result is discarded.

Test Plan:
- Single drain, row-major: y elements (r,c) = r*4+c+1 (1..16), pulse done 1 cycle, m_ready=1.
  - m_valid rises 1 cycle after done.
  - 16 consecutive beats carry 1..16 with (row,col) = (0,0)…(3,3).
  - m_last only on value 16; busy drops the cycle after.
- Backpressure: same data, m_ready toggles 1,0,0,1,…
  - m_data/m_row/m_col stay constant while m_ready=0.
  - Exactly 16 accepts, sequence 1..16, no duplicates or skips.
- Column-major: COL_MAJOR=1, same y.
  - Beat order 1,5,9,13,2,6,…,16; m_row cycles 0..3 fastest.
- Level hold / overrun:
  - done held high 40 cycles → exactly one drain, no overrun.
  - Second rise (new y = 100..115) at beat 5 → overrun pulses one cycle; stream still outputs 1..16.
- Back-to-back: rise with y = 100..115 on the same cycle the m_last beat (16) is accepted.
  - Next cycle m_valid=1, m_data=100, (0,0); no idle cycle.
- Reset mid-drain: reset=0 after beat 7.
  - Next cycle m_valid=0, busy=0, indices 0.
  - A fresh done rise then drains from element (0,0).
